// File: rtl/sensor_pkg.sv
// -----------------------------------------------------------------------------
// sensor_pkg
// Shared definitions for the sensor threshold monitor:
//   SAMPLE_W     - width of sensor samples and averages (8 bits)
//   mon_state_e  - alarm FSM states
//   evt_code_e   - event codes reported on the event interface
// -----------------------------------------------------------------------------
package sensor_pkg;

  localparam int SAMPLE_W = 8;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_PEND_HI  = 2'd1,
    ST_ALARM    = 2'd2,
    ST_PEND_CLR = 2'd3
  } mon_state_e;

  typedef enum logic [1:0] {
    EVT_NONE  = 2'b00,
    EVT_RAISE = 2'b01,
    EVT_CLEAR = 2'b10
  } evt_code_e;

endpackage

// File: rtl/sensor_avg_filter.sv
// -----------------------------------------------------------------------------
// sensor_avg_filter
// Moving-average filter over the last AVG_DEPTH samples (AVG_DEPTH must be a
// power of two, 2..16).
//
// Ports:
//   clk          in   clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   sample_data  in   [SAMPLE_W-1:0] unsigned sample
//   sample_valid in   one sample accepted per high cycle
//   avg_data     out  [SAMPLE_W-1:0] truncated average, holds between updates
//   avg_valid    out  one-cycle pulse the cycle after a sample that produced
//                     a new average (only once the window has been filled)
// -----------------------------------------------------------------------------
module sensor_avg_filter
  import sensor_pkg::*;
#(
  parameter int AVG_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                sample_valid,
  output logic [SAMPLE_W-1:0] avg_data,
  output logic                avg_valid
);

  localparam int LOG2_D = $clog2(AVG_DEPTH);
  localparam int SUM_W  = SAMPLE_W + LOG2_D;
  localparam int FILL_W = $clog2(AVG_DEPTH + 1);

  logic [SAMPLE_W-1:0] win_q [AVG_DEPTH];
  logic [SAMPLE_W-1:0] win_d [AVG_DEPTH];
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [SAMPLE_W-1:0] avg_data_q, avg_data_d;
  logic                avg_valid_q, avg_valid_d;

  always_comb begin
    win_d       = win_q;
    sum_d       = sum_q;
    fill_d      = fill_q;
    avg_data_d  = avg_data_q;
    avg_valid_d = 1'b0;

    if (sample_valid) begin
      win_d[0] = sample_data;
      for (int i = 1; i < AVG_DEPTH; i++) begin
        win_d[i] = win_q[i-1];
      end
      // The oldest slot is zero until the window fills, so the running sum
      // is exact from the first sample on.
      sum_d = sum_q - SUM_W'(win_q[AVG_DEPTH-1]) + SUM_W'(sample_data);

      // Fill counter saturates at AVG_DEPTH.
      if (fill_q != FILL_W'(AVG_DEPTH)) begin
        fill_d = fill_q + FILL_W'(1);
      end

      if (fill_d == FILL_W'(AVG_DEPTH)) begin
        avg_valid_d = 1'b1;
        avg_data_d  = SAMPLE_W'(sum_d >> LOG2_D);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < AVG_DEPTH; i++) begin
        win_q[i] <= '0;
      end
      sum_q       <= '0;
      fill_q      <= '0;
      avg_data_q  <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      win_q       <= win_d;
      sum_q       <= sum_d;
      fill_q      <= fill_d;
      avg_data_q  <= avg_data_d;
      avg_valid_q <= avg_valid_d;
    end
  end

  assign avg_data  = avg_data_q;
  assign avg_valid = avg_valid_q;

endmodule

// File: rtl/sensor_threshold_monitor.sv
// -----------------------------------------------------------------------------
// sensor_threshold_monitor
// Averages incoming sensor samples, runs a debounced hysteresis alarm FSM on
// the averages and reports alarm raise/clear events through a single-entry
// event register.
//
// Parameters:
//   AVG_DEPTH  moving-average window (power of two, 2..16)
//   DEBOUNCE   consecutive qualifying averages to raise/clear (1..15)
//
// Ports:
//   clk, reset_n               clock / asynchronous active-low reset
//   sample_data, sample_valid  sample input
//   thresh_hi, thresh_lo       raise (avg > hi) / clear (avg < lo) thresholds
//   avg_data, avg_valid        moving average and its update pulse
//   alarm                      high while in ALARM or PEND_CLR (registered)
//   event_valid, event_ready   event handshake
//   event_code, event_value    EVT_RAISE / EVT_CLEAR and triggering average
//   overrun, overrun_clr       sticky lost-event flag and its clear
//   state_dbg                  current FSM state (mon_state_e encoding)
//
// Event handshake: an event is transferred on every cycle where event_valid
// and event_ready are both high. While event_valid is high and no transfer
// happens, event_code and event_value hold stable. A new event arriving while
// the register is full and not transferring is dropped and sets overrun; a
// new event arriving in the transfer cycle replaces the old one.
// -----------------------------------------------------------------------------
module sensor_threshold_monitor
  import sensor_pkg::*;
#(
  parameter int AVG_DEPTH = 4,
  parameter int DEBOUNCE  = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] thresh_hi,
  input  logic [SAMPLE_W-1:0] thresh_lo,
  output logic [SAMPLE_W-1:0] avg_data,
  output logic                avg_valid,
  output logic                alarm,
  output logic                event_valid,
  input  logic                event_ready,
  output logic [1:0]          event_code,
  output logic [SAMPLE_W-1:0] event_value,
  output logic                overrun,
  input  logic                overrun_clr,
  output logic [1:0]          state_dbg
);

  localparam int CNT_W = 4;

  // ---------------------------------------------------------------------------
  // Averaging
  // ---------------------------------------------------------------------------
  sensor_avg_filter #(
    .AVG_DEPTH (AVG_DEPTH)
  ) u_avg (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .avg_data     (avg_data),
    .avg_valid    (avg_valid)
  );

  // ---------------------------------------------------------------------------
  // Alarm FSM, debounce counter and event staging
  // ---------------------------------------------------------------------------
  mon_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  // Staging flop: an event decided on a transition is loaded into the event
  // register one cycle later, aligned with the registered alarm output.
  logic                new_evt_q, new_evt_d;
  evt_code_e           new_code_q, new_code_d;
  logic [SAMPLE_W-1:0] new_val_q, new_val_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    new_evt_d  = 1'b0;
    new_code_d = new_code_q;
    new_val_d  = new_val_q;

    if (avg_valid) begin
      case (state_q)
        ST_NORMAL: begin
          if (avg_data > thresh_hi) begin
            if (DEBOUNCE == 1) begin
              state_d    = ST_ALARM;
              cnt_d      = '0;
              new_evt_d  = 1'b1;
              new_code_d = EVT_RAISE;
              new_val_d  = avg_data;
            end else begin
              state_d = ST_PEND_HI;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_PEND_HI: begin
          if (avg_data > thresh_hi) begin
            if (cnt_q + CNT_W'(1) == CNT_W'(DEBOUNCE)) begin
              state_d    = ST_ALARM;
              cnt_d      = '0;
              new_evt_d  = 1'b1;
              new_code_d = EVT_RAISE;
              new_val_d  = avg_data;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = ST_NORMAL;
            cnt_d   = '0;
          end
        end
        ST_ALARM: begin
          if (avg_data < thresh_lo) begin
            if (DEBOUNCE == 1) begin
              state_d    = ST_NORMAL;
              cnt_d      = '0;
              new_evt_d  = 1'b1;
              new_code_d = EVT_CLEAR;
              new_val_d  = avg_data;
            end else begin
              state_d = ST_PEND_CLR;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_PEND_CLR: begin
          if (avg_data < thresh_lo) begin
            if (cnt_q + CNT_W'(1) == CNT_W'(DEBOUNCE)) begin
              state_d    = ST_NORMAL;
              cnt_d      = '0;
              new_evt_d  = 1'b1;
              new_code_d = EVT_CLEAR;
              new_val_d  = avg_data;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = ST_ALARM;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_NORMAL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered alarm and event register
  // ---------------------------------------------------------------------------
  logic                alarm_q, alarm_d;
  logic                ev_valid_q, ev_valid_d;
  evt_code_e           ev_code_q, ev_code_d;
  logic [SAMPLE_W-1:0] ev_value_q, ev_value_d;
  logic                overrun_q, overrun_d;
  logic                accept;
  logic                drop;

  always_comb begin
    alarm_d    = (state_q == ST_ALARM) || (state_q == ST_PEND_CLR);
    accept     = ev_valid_q & event_ready;
    drop       = new_evt_q & ev_valid_q & ~accept;
    ev_valid_d = ev_valid_q;
    ev_code_d  = ev_code_q;
    ev_value_d = ev_value_q;
    overrun_d  = overrun_q;

    if (new_evt_q && !drop) begin
      ev_valid_d = 1'b1;
      ev_code_d  = new_code_q;
      ev_value_d = new_val_q;
    end else if (accept) begin
      ev_valid_d = 1'b0;
    end

    // Set has priority over clear so a loss in the clear cycle is not hidden.
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    if (drop) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_NORMAL;
      cnt_q      <= '0;
      new_evt_q  <= 1'b0;
      new_code_q <= EVT_NONE;
      new_val_q  <= '0;
      alarm_q    <= 1'b0;
      ev_valid_q <= 1'b0;
      ev_code_q  <= EVT_NONE;
      ev_value_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      new_evt_q  <= new_evt_d;
      new_code_q <= new_code_d;
      new_val_q  <= new_val_d;
      alarm_q    <= alarm_d;
      ev_valid_q <= ev_valid_d;
      ev_code_q  <= ev_code_d;
      ev_value_q <= ev_value_d;
      overrun_q  <= overrun_d;
    end
  end

  assign alarm       = alarm_q;
  assign event_valid = ev_valid_q;
  assign event_code  = ev_code_q;
  assign event_value = ev_value_q;
  assign overrun     = overrun_q;
  assign state_dbg   = state_q;

endmodule
